// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response channel between the datapath (master)
// and the memory responder (slave).
interface mem_responder_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;
   logic              busy;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err, busy
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err, busy
   );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory target with WAIT_CYCLES wait states,
// one outstanding request, valid/ready request and response channels.
// Optional feature macro: MEM_BOUNDS_CHECK_EN (out-of-range addresses are
// answered with resp_err=1, rdata 0 and no write). Without it, addresses
// alias modulo DEPTH and resp_err stays 0.
module mem_responder #(
   parameter int DEPTH       = 256,
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 16,
   parameter int WAIT_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   mem_responder_if.slave  bus
);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic              r_err;
   logic [3:0]        r_cnt;
   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_req_ready;
   logic              w_resp_valid;
   logic              w_busy;
   logic              w_accept;
   logic              w_commit;
   logic              w_done;
   logic              w_oob;
   logic [IDX_W-1:0]  w_idx;

   assign w_idx    = r_addr[IDX_W-1:0];
   assign w_accept = bus.req_valid && w_req_ready;
   assign w_commit = (r_state == S_WAIT) && (r_cnt == 4'd0);
   assign w_done   = (r_state == S_RESP) && bus.resp_ready;

`ifdef MEM_BOUNDS_CHECK_EN
   // Zero-extend by one bit so DEPTH == 2**ADDR_W still compares correctly
   assign w_oob = ({1'b0, r_addr} >= (ADDR_W + 1)'(DEPTH));
`else
   assign w_oob = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_next = S_WAIT;
            else          w_next = S_IDLE;
         end
         S_WAIT: begin
            if (w_commit) w_next = S_RESP;
            else          w_next = S_WAIT;
         end
         S_RESP: begin
            if (w_done) w_next = S_IDLE;
            else        w_next = S_RESP;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Handshake outputs decoded purely from the registered state
   always_comb begin
      w_req_ready  = 1'b0;
      w_resp_valid = 1'b0;
      w_busy       = 1'b1;
      case (r_state)
         S_IDLE: begin
            w_req_ready  = 1'b1;
            w_resp_valid = 1'b0;
            w_busy       = 1'b0;
         end
         S_WAIT: begin
            w_req_ready  = 1'b0;
            w_resp_valid = 1'b0;
            w_busy       = 1'b1;
         end
         S_RESP: begin
            w_req_ready  = 1'b0;
            w_resp_valid = 1'b1;
            w_busy       = 1'b1;
         end
         default: begin
            w_req_ready  = 1'b0;
            w_resp_valid = 1'b0;
            w_busy       = 1'b1;
         end
      endcase
   end

   // Request capture, wait-state counter and response data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we    <= 1'b0;
         r_addr  <= {ADDR_W{1'b0}};
         r_wdata <= {DATA_W{1'b0}};
         r_rdata <= {DATA_W{1'b0}};
         r_err   <= 1'b0;
         r_cnt   <= 4'd0;
      end else begin
         if (w_accept) begin
            r_we    <= bus.req_we;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_cnt   <= 4'(WAIT_CYCLES);
         end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
         end
         // Response fields change only at commit, so they hold through RESP
         if (w_commit) begin
            r_err <= w_oob;
            if (r_we || w_oob) r_rdata <= {DATA_W{1'b0}};
            else               r_rdata <= r_mem[w_idx];
         end
      end
   end

   // Memory array: not reset, so contents survive rst_n
   always_ff @(posedge clk) begin
      if (w_commit && r_we && !w_oob) begin
         r_mem[w_idx] <= r_wdata;
      end
   end

   assign bus.req_ready  = w_req_ready;
   assign bus.resp_valid = w_resp_valid;
   assign bus.resp_rdata = r_rdata;
   assign bus.resp_err   = r_err;
   assign bus.busy       = w_busy;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed stimulus with a scoreboard queue; a monitor
// checks response latency, stability and contents against queued entries.
module tb_mem_responder;
   localparam int WAIT = 2;
   localparam int LAT  = WAIT + 2;

`ifdef MEM_BOUNDS_CHECK_EN
   localparam logic        BND_ERR  = 1'b1;
   localparam logic [15:0] MEM0_EXP = 16'h0F0F;
   localparam logic [15:0] OOB_RD   = 16'h0000;
`else
   localparam logic        BND_ERR  = 1'b0;
   localparam logic [15:0] MEM0_EXP = 16'h1234;
   localparam logic [15:0] OOB_RD   = 16'h1234;
`endif

   typedef struct packed {
      logic [15:0] d;
      logic        e;
      int          t;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_chk;
   int   n_pass;
   exp_t exp_q[$];
   logic        prev_v;
   logic [15:0] prev_d;
   int   acc[3];

   mem_responder_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   mem_responder #(
      .DEPTH(256), .DATA_W(16), .ADDR_W(16), .WAIT_CYCLES(WAIT)
   ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: latency on first valid, stability while stalled, data on handshake
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         prev_v <= 1'b0;
         prev_d <= 16'h0000;
      end else begin
         if (bus.resp_valid && !prev_v) begin
            if (exp_q.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
            else chk("resp_latency", cyc, exp_q[0].t);
         end
         if (bus.resp_valid && prev_v) chk("rdata_stable", {16'h0, bus.resp_rdata}, {16'h0, prev_d});
         if (bus.resp_valid && bus.resp_ready && exp_q.size() != 0) begin
            chk("resp_rdata", {16'h0, bus.resp_rdata}, {16'h0, exp_q[0].d});
            chk("resp_err", {31'h0, bus.resp_err}, {31'h0, exp_q[0].e});
            void'(exp_q.pop_front());
         end
         prev_v <= bus.resp_valid;
         prev_d <= bus.resp_rdata;
      end
   end

   task automatic do_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] exp_d, input logic exp_e);
      int n;
      exp_t e;
      @(posedge clk); #1;
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      n = 0;
      @(negedge clk);
      while (!bus.req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("req_accept", {31'h0, bus.req_ready}, 32'd1);
      if (bus.req_ready) begin
         e.d = exp_d; e.e = exp_e; e.t = cyc + LAT;
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      // Scramble inputs after accept: they must have no effect
      bus.req_valid = 1'b0;
      bus.req_we    = ~we;
      bus.req_addr  = ~addr;
      bus.req_wdata = ~wdata;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus.busy) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain_queue", exp_q.size(), 32'd0);
      chk("drain_busy", {31'h0, bus.busy}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n;
      int   k;
      exp_t e;
      n_chk = 0; n_pass = 0; cyc = 0;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 16'h0;
      bus.req_wdata = 16'h0; bus.resp_ready = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_req_ready", {31'h0, bus.req_ready}, 32'd1);
      chk("rst_resp_valid", {31'h0, bus.resp_valid}, 32'd0);
      chk("rst_rdata", {16'h0, bus.resp_rdata}, 32'd0);
      chk("rst_err", {31'h0, bus.resp_err}, 32'd0);
      chk("rst_busy", {31'h0, bus.busy}, 32'd0);

      // Write then read
      bus.resp_ready = 1'b1;
      do_req(1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0);
      do_req(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);
      wait_idle();

      // Backpressure: hold resp_ready low for 5 response cycles
      bus.resp_ready = 1'b0;
      do_req(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);
      n = 0;
      while (!bus.resp_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", {31'h0, bus.resp_valid}, 32'd1);
         chk("bp_rdata", {16'h0, bus.resp_rdata}, 32'h0000BEEF);
         chk("bp_req_ready", {31'h0, bus.req_ready}, 32'd0);
         if (i < 4) @(negedge clk);
      end
      @(posedge clk); #1;
      bus.resp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_idle_busy", {31'h0, bus.busy}, 32'd0);
      chk("bp_idle_ready", {31'h0, bus.req_ready}, 32'd1);
      wait_idle();

      // Back-to-back reads with req_valid held high
      do_req(1'b1, 16'h0001, 16'h1111, 16'h0000, 1'b0);
      do_req(1'b1, 16'h0002, 16'h2222, 16'h0000, 1'b0);
      do_req(1'b1, 16'h0003, 16'h3333, 16'h0000, 1'b0);
      wait_idle();
      @(posedge clk); #1;
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 16'h0001;
      k = 0; n = 0;
      while (k < 3 && n < 100) begin
         @(negedge clk);
         n++;
         if (bus.req_ready) begin
            acc[k] = cyc;
            e.d = {4{4'(k + 1)}}; e.e = 1'b0; e.t = cyc + LAT;
            exp_q.push_back(e);
            k++;
            @(posedge clk); #1;
            if (k < 3) bus.req_addr = 16'(k + 1);
            else       bus.req_valid = 1'b0;
         end
      end
      chk("b2b_accepts", k, 32'd3);
      if (k == 3) begin
         chk("b2b_spacing1", acc[1] - acc[0], WAIT + 3);
         chk("b2b_spacing2", acc[2] - acc[1], WAIT + 3);
      end
      wait_idle();

      // Bounds / aliasing
      do_req(1'b1, 16'h0000, 16'h0F0F, 16'h0000, 1'b0);
      do_req(1'b1, 16'h0100, 16'h1234, 16'h0000, BND_ERR);
      do_req(1'b0, 16'h0000, 16'h0000, MEM0_EXP, 1'b0);
      do_req(1'b0, 16'h0100, 16'h0000, OOB_RD, BND_ERR);
      wait_idle();

      // Reset during WAIT aborts the write
      do_req(1'b1, 16'h0005, 16'h5555, 16'h0000, 1'b0);
      wait_idle();
      @(posedge clk); #1;
      bus.req_valid = 1'b1; bus.req_we = 1'b1;
      bus.req_addr = 16'h0005; bus.req_wdata = 16'hAAAA;
      n = 0;
      @(negedge clk);
      while (!bus.req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      chk("pre_rst_busy", {31'h0, bus.busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_req_ready", {31'h0, bus.req_ready}, 32'd1);
      chk("midrst_resp_valid", {31'h0, bus.resp_valid}, 32'd0);
      chk("midrst_busy", {31'h0, bus.busy}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      do_req(1'b0, 16'h0005, 16'h0000, 16'h5555, 1'b0);
      wait_idle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/mem_responder.md
# mem_responder

Word-addressed 16-bit memory target serving the multicycle datapath's load/store and instruction-fetch port. The datapath issues requests over a valid/ready request channel. This block inserts a configurable number of wait states, commits the access, and returns a response over a valid/ready response channel. It models the memory side of the processor's memory interface, so the datapath can be checked against a non-zero-latency memory.

## Interface
- DEPTH, 256, number of 16-bit words; must be a power of two
- DATA_W, 16, data width
- ADDR_W, 16, request address width
- WAIT_CYCLES, 2, extra wait states before commit; range 0..15
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_we  input  1  1 = write, 0 = read
- req_addr  input  ADDR_W  word address
- req_wdata  input  DATA_W  write data
- resp_valid  output  1  response present
- resp_ready  input  1  datapath accepts the response
- resp_rdata  output  DATA_W  read data; 0 for writes
- resp_err  output  1  access error (see Configuration)
- busy  output  1  state != IDLE

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE
  - req_ready = 1.
  - On req_valid && req_ready: capture we, addr and wdata; load wait counter with WAIT_CYCLES; go to WAIT.
- WAIT
  - req_ready = 0.
  - If counter != 0, decrement it and stay in WAIT.
  - If counter == 0, commit the access and go to RESP.
    - Write: mem[idx] <= wdata; resp_rdata <= 0.
    - Read: resp_rdata <= mem[idx].
- RESP
  - resp_valid = 1.
  - resp_rdata and resp_err are held stable until resp_valid && resp_ready, then go to IDLE.
- idx = addr[log2(DEPTH)-1:0]. Without bounds checking, upper address bits alias.
- Request inputs are sampled only in the accept cycle. Changes afterwards have no effect.
- Memory array is not reset; contents survive rst_n.
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, busy 0, counter 0.
- Reset mid-operation:
  - Asserting rst_n low in WAIT aborts the request and no write occurs.
  - Asserting it in RESP drops the response; the write has already been committed.

## Timing
- req_ready and resp_valid are decoded from registered state only; no combinational input-to-output path.
- Accept in cycle T: the access commits at the clock edge ending cycle T+WAIT_CYCLES+1, and resp_valid first asserts in cycle T+WAIT_CYCLES+2.
- Response handshake in cycle R: IDLE in R+1, so the earliest next accept is R+1.
- Minimum request spacing is WAIT_CYCLES+3 cycles.
- resp_ready low stalls indefinitely in RESP with all outputs stable.
- resp_ready high before resp_valid is ignored.
- Only one request is ever outstanding.

## Configuration
- MEM_BOUNDS_CHECK_EN defined: a request with req_addr >= DEPTH is accepted and takes normal latency, but:
  - no write occurs;
  - resp_rdata = 0;
  - resp_err = 1.
- MEM_BOUNDS_CHECK_EN undefined: addresses alias modulo DEPTH; resp_err is tied 0.

## Test plan
- Write then read, WAIT_CYCLES=2, resp_ready=1:
  - Write addr 0x0010 data 0xBEEF accepted at T → resp_valid at T+4 with rdata 0, err 0.
  - Read 0x0010 → resp_rdata 0xBEEF at the fourth cycle after accept.
- Backpressure: read response with resp_ready held low 5 cycles → resp_valid and resp_rdata stable all 5 cycles; req_ready 0 throughout; IDLE the cycle after resp_ready rises.
- Back-to-back: req_valid held high with reads of addresses 1, 2, 3 → accepts spaced exactly WAIT_CYCLES+3 = 5 cycles apart; data returned in order.
- Bounds:
  - Write 0x0100 data 0x1234 with DEPTH=256.
  - Macro defined → resp_err 1, mem[0] unchanged.
  - Macro undefined → resp_err 0, mem[0] = 0x1234 on readback.
- Reset mid-WAIT: write 0x0005 data 0xAAAA, pulse rst_n low one cycle after accept → req_ready 1, resp_valid 0, busy 0 immediately; later read of 0x0005 returns the prior value, not 0xAAAA.
